senone_param_store: RTL

SENONE_PARAM_STORE -- requirements
Module: senone_param_store

---
 rtl/senone_param_store.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/senone_param_store.sv
// Senone parameter store: holds per-senone k and per-component omega/mean words,
// loaded through a simple write port, and streams one senone on request as a
// sequence of component beats with valid/ready handshaking.
module senone_param_store #(
    parameter int unsigned N_COMPONENTS = 25,
    parameter int unsigned N_SENONES    = 32,
    parameter int unsigned NUM_W        = 16,
    parameter int unsigned IDX_W        = $clog2(N_SENONES) + 1,
    parameter int unsigned CMP_W        = $clog2(N_COMPONENTS)
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             wr_en,
    output logic             wr_ready,
    input  logic [1:0]       wr_field,
    input  logic [IDX_W-1:0] wr_senone,
    input  logic [CMP_W-1:0] wr_comp,
    input  logic [NUM_W-1:0] wr_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_senone,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] out_k,
    output logic [NUM_W-1:0] out_omega,
    output logic [NUM_W-1:0] out_mean,
    output logic [CMP_W-1:0] out_comp,
    output logic             out_last,
    output logic             out_err
);

    localparam int unsigned SEN_AW = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
    localparam int unsigned DEPTH  = N_SENONES * N_COMPONENTS;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] FieldK     = 2'd0;
    localparam logic [1:0] FieldOmega = 2'd1;
    localparam logic [1:0] FieldMean  = 2'd2;

    localparam logic [CMP_W-1:0] LastComp = CMP_W'(N_COMPONENTS - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    // Range checks are done at 32 bits so they hold even when N_* is a power of two.
    function automatic logic sen_in_range(input logic [IDX_W-1:0] s);
        return 32'(s) < N_SENONES;
    endfunction

    function automatic logic comp_in_range(input logic [CMP_W-1:0] c);
        return 32'(c) < N_COMPONENTS;
    endfunction

    // Flat word address of (senone, component); only meaningful for in-range indices.
    function automatic logic [MEM_AW-1:0] flat_addr(input logic [IDX_W-1:0] s,
                                                    input logic [CMP_W-1:0] c);
        return MEM_AW'(s[SEN_AW-1:0]) * MEM_AW'(N_COMPONENTS) + MEM_AW'(c);
    endfunction

    // Parameter storage; deliberately not reset.
    logic [NUM_W-1:0] k_mem     [N_SENONES];
    logic [NUM_W-1:0] omega_mem [DEPTH];
    logic [NUM_W-1:0] mean_mem  [DEPTH];

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sen_q, sen_d;
    logic [CMP_W-1:0] comp_q, comp_d;
    logic             out_valid_q, out_valid_d;
    logic [NUM_W-1:0] out_k_q, out_k_d;
    logic [NUM_W-1:0] out_omega_q, out_omega_d;
    logic [NUM_W-1:0] out_mean_q, out_mean_d;
    logic             out_last_q, out_last_d;
    logic             out_err_q, out_err_d;

    logic              idle;
    logic              wr_fire;
    logic              wr_k, wr_omega, wr_mean;
    logic [MEM_AW-1:0] wr_addr;

    logic [IDX_W-1:0]  rd_sen;
    logic [CMP_W-1:0]  rd_comp;
    logic [MEM_AW-1:0] rd_addr;
    logic [NUM_W-1:0]  rd_k, rd_omega, rd_mean;

    // Write-port decode: only accepted in IDLE, outside reset, to a legal address.
    always_comb begin
        idle      = (state_q == StIdle);
        wr_ready  = idle;
        req_ready = idle;
        wr_addr   = flat_addr(wr_senone, wr_comp);
        wr_fire   = nReset && wr_en && idle && sen_in_range(wr_senone);
        wr_k      = wr_fire && (wr_field == FieldK);
        wr_omega  = wr_fire && (wr_field == FieldOmega) && comp_in_range(wr_comp);
        wr_mean   = wr_fire && (wr_field == FieldMean) && comp_in_range(wr_comp);
    end

    // Commit accepted writes into the parameter arrays.
    always_ff @(posedge clk) begin
        if (wr_k) begin
            k_mem[wr_senone[SEN_AW-1:0]] <= wr_data;
        end
        if (wr_omega) begin
            omega_mem[wr_addr] <= wr_data;
        end
        if (wr_mean) begin
            mean_mem[wr_addr] <= wr_data;
        end
    end

    // Read the beat about to be loaded; a same-edge write is forwarded so a
    // request accepted together with a write sees the new value.
    always_comb begin
        rd_sen   = idle ? req_senone : sen_q;
        rd_comp  = idle ? '0 : comp_q + CMP_W'(1);
        rd_addr  = flat_addr(rd_sen, rd_comp);
        rd_k     = k_mem[rd_sen[SEN_AW-1:0]];
        rd_omega = omega_mem[rd_addr];
        rd_mean  = mean_mem[rd_addr];
        if (wr_k && (wr_senone == rd_sen)) begin
            rd_k = wr_data;
        end
        if (wr_omega && (wr_addr == rd_addr)) begin
            rd_omega = wr_data;
        end
        if (wr_mean && (wr_addr == rd_addr)) begin
            rd_mean = wr_data;
        end
    end

    // Next-state and next-beat computation for the streaming FSM.
    always_comb begin
        state_d     = state_q;
        sen_d       = sen_q;
        comp_d      = comp_q;
        out_valid_d = out_valid_q;
        out_k_d     = out_k_q;
        out_omega_d = out_omega_q;
        out_mean_d  = out_mean_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d     = StStream;
                    sen_d       = req_senone;
                    comp_d      = '0;
                    out_valid_d = 1'b1;
                    if (sen_in_range(req_senone)) begin
                        out_k_d     = rd_k;
                        out_omega_d = rd_omega;
                        out_mean_d  = rd_mean;
                        out_last_d  = (N_COMPONENTS == 1);
                        out_err_d   = 1'b0;
                    end else begin
                        // Bad index: a single zero-data error beat.
                        out_k_d     = '0;
                        out_omega_d = '0;
                        out_mean_d  = '0;
                        out_last_d  = 1'b1;
                        out_err_d   = 1'b1;
                    end
                end
            end
            StStream: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = StIdle;
                        comp_d      = '0;
                        out_valid_d = 1'b0;
                        out_k_d     = '0;
                        out_omega_d = '0;
                        out_mean_d  = '0;
                        out_last_d  = 1'b0;
                        out_err_d   = 1'b0;
                    end else begin
                        // k is re-read from the same senone, so it stays constant.
                        comp_d      = rd_comp;
                        out_k_d     = rd_k;
                        out_omega_d = rd_omega;
                        out_mean_d  = rd_mean;
                        out_last_d  = (rd_comp == LastComp);
                        out_err_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and registered beat outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q     <= StIdle;
            sen_q       <= '0;
            comp_q      <= '0;
            out_valid_q <= 1'b0;
            out_k_q     <= '0;
            out_omega_q <= '0;
            out_mean_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sen_q       <= sen_d;
            comp_q      <= comp_d;
            out_valid_q <= out_valid_d;
            out_k_q     <= out_k_d;
            out_omega_q <= out_omega_d;
            out_mean_q  <= out_mean_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_k     = out_k_q;
    assign out_omega = out_omega_q;
    assign out_mean  = out_mean_q;
    assign out_comp  = comp_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule
